schwap_writeback_seq: RTL and testbench
=======================================

Name: schwap_writeback_seq

Overview:
Writeback sequencer sitting directly upstream of the register file's write port and schwap (banked register) controls.
- Accepts result writes from the execute/memory stages through a valid/ready handshake and buffers them in a small FIFO.
- Drains each entry to the register file as a single-cycle write pulse.
- For writes to banked registers (addresses BANK_BASE..15), first selects the target bank via schwapReg and a one-cycle schwapClk pulse, but only when the bank actually differs from the one currently selected.

Parameters:
DEPTH, 2, input FIFO entries (power of two, >=2)
BANK_BASE, 12, lowest banked register address
DATA_W, 16, register data width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream request valid
in_ready  out  1  FIFO can accept (= not full)
in_swap_only  in  1  request is a bank select only; no register write
in_addr  in  4  destination register
in_bank  in  2  bank for banked addresses (ignored when in_addr < BANK_BASE)
in_data  in  DATA_W  write data
write  out  1  register file write enable
writeAddr  out  4  register file write address
writeData  out  DATA_W  register file write data
schwapReg  out  4  bank select to register file, upper 2 bits always 0
schwapClk  out  1  bank latch strobe to register file
cur_bank  out  2  bank currently selected in register file
bank_known  out  1  cur_bank is valid (register file bank is not reset)
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values: FIFO empty, FSM IDLE, write=0, schwapClk=0, schwapReg=0, writeAddr=0, writeData=0, cur_bank=0, bank_known=0, busy=0, in_ready=1.
- Enqueue: on in_valid && in_ready. in_ready = !full, registered-count based. No bypass: a full FIFO refuses even if a dequeue happens in the same cycle. Enqueue and dequeue in the same cycle are legal when not full.
- Dequeue: occurs only in IDLE with the FIFO non-empty. The head is classified as:
  - banked = in_swap_only || addr >= BANK_BASE
  - need_swap = banked && (!bank_known || bank != cur_bank)
- FSM states and transitions:
  - IDLE: if head present: need_swap -> SEL; else if !swap_only -> WRITE; else (swap-only, bank already selected) pop with no output activity, stay IDLE.
  - SEL: schwapReg = {2'b0, bank}, schwapClk = 0 (setup cycle) -> STROBE.
  - STROBE: schwapClk = 1, schwapReg held. On exit, cur_bank <= bank and bank_known <= 1. Next state is WRITE, or IDLE (with pop) if swap_only.
  - WRITE: write = 1; writeAddr and writeData from the head. Pop head -> IDLE.
- Timing and latency:
  - schwapReg is held stable from SEL through WRITE.
  - Cycles from head reaching IDLE to the write cycle: 1 for an unbanked/no-swap write, 3 for a swap write (SEL, STROBE, WRITE).
  - Enqueue-to-write latency when the FIFO is empty and the FSM is IDLE: 2 cycles (no swap).
- Output timing:
  - write and schwapClk are registered, one-cycle pulses. They are never asserted in the same cycle.
  - writeAddr and writeData hold their last value when write = 0.
- Back-to-back: IDLE is always visited between operations, so the peak rate is one write per 2 cycles.
- FIFO pointers wrap modulo DEPTH.
- Reset mid-operation: all state is cleared asynchronously, including an in-flight STROBE or WRITE and pending FIFO entries (dropped). bank_known=0 forces a swap before the next banked write.

Decomposition:
- Shared package: FSM state enum (IDLE, SEL, STROBE, WRITE), BANK_BASE default, and a request struct {swap_only, addr[3:0], bank[1:0], data}.
- One sub-module, wb_req_fifo: parameterised DEPTH sync FIFO with full/empty flags and async reset. The sequencer FSM stays in the top module.

Test Plan:
- Reset, enqueue addr=3 data=0x0003 -> write=1 exactly 2 cycles later with writeAddr=3, writeData=3; schwapClk never asserted.
- After reset, enqueue addr=13 bank=2 data=0x000F -> SEL (schwapReg=2), STROBE (schwapClk=1), then write to 13; cur_bank=2, bank_known=1.
- Follow-up addr=14 bank=2 -> no strobe, direct write. Then addr=14 bank=1 -> strobe with schwapReg=1, then write.
- Hold in_valid with 6 requests -> in_ready falls after 2 are accepted. All 6 writes emerge in order, 0..5 data intact, no loss or duplicate.
- swap_only bank=3 with cur_bank=3 -> no output pulses, busy clears. swap_only bank=0 -> single schwapClk pulse, no write, cur_bank=0.
- Assert rst during STROBE with 2 entries queued -> outputs 0 immediately, FIFO empty, bank_known=0. Next banked write, even to the previous bank, strobes first.

Source files
------------

// File: rtl/schwap_writeback_seq_pkg.sv
// schwap_writeback_seq_pkg: shared FSM states, defaults and request record for the writeback sequencer.
package schwap_writeback_seq_pkg;
  localparam int BANK_BASE_DEF = 12;
  localparam int WB_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, SEL, STROBE, WRITE} state_t;
  typedef struct packed {
    logic swap_only;
    logic [3:0] addr;
    logic [1:0] bank;
    logic [WB_DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/schwap_writeback_seq_if.sv
// schwap_writeback_seq_if: upstream request handshake plus register-file write/bank-select bus.
interface schwap_writeback_seq_if import schwap_writeback_seq_pkg::*; #(parameter int DATA_W = WB_DATA_W);
  logic in_valid;
  logic in_ready;
  logic in_swap_only;
  logic [3:0] in_addr;
  logic [1:0] in_bank;
  logic [DATA_W-1:0] in_data;
  logic write;
  logic [3:0] writeAddr;
  logic [DATA_W-1:0] writeData;
  logic [3:0] schwapReg;
  logic schwapClk;
  logic [1:0] cur_bank;
  logic bank_known;
  logic busy;
  modport slave (
    input in_valid, in_swap_only, in_addr, in_bank, in_data,
    output in_ready, write, writeAddr, writeData, schwapReg, schwapClk, cur_bank, bank_known, busy
  );
  modport master (
    output in_valid, in_swap_only, in_addr, in_bank, in_data,
    input in_ready, write, writeAddr, writeData, schwapReg, schwapClk, cur_bank, bank_known, busy
  );
endinterface

// File: rtl/schwap_writeback_seq_wb_req_fifo.sv
// wb_req_fifo: DEPTH-entry synchronous FIFO with count-based full/empty flags and async reset.
module wb_req_fifo import schwap_writeback_seq_pkg::*; #(
  parameter int DEPTH = 2,
  parameter type T = req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  T     i_din,
  output T     o_dout,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_dout = r_mem[r_rp];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/schwap_writeback_seq.sv
// schwap_writeback_seq: buffers result writes and drains them to the register file,
// strobing a bank select first whenever a banked target's bank is not already latched.
module schwap_writeback_seq import schwap_writeback_seq_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int BANK_BASE = BANK_BASE_DEF,
  parameter int DATA_W = WB_DATA_W
) (
  input logic clk,
  input logic rst,
  schwap_writeback_seq_if.slave bus
);
  localparam logic [3:0] BB = 4'(BANK_BASE);
  state_t r_state, w_nxt;
  req_t w_head, w_din;
  logic w_full, w_empty, w_pop, w_banked, w_need;
  logic r_write, r_strobe, r_known;
  logic [1:0] r_sreg, r_cur;
  logic [3:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  assign w_din = '{swap_only: bus.in_swap_only, addr: bus.in_addr, bank: bus.in_bank, data: bus.in_data};
  wb_req_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
    .clk(clk), .rst(rst), .i_push(bus.in_valid), .i_pop(w_pop), .i_din(w_din),
    .o_dout(w_head), .o_full(w_full), .o_empty(w_empty)
  );
  assign w_banked = w_head.swap_only || w_head.addr >= BB;
  assign w_need = w_banked && (!r_known || w_head.bank != r_cur);
  always_comb begin
    w_nxt = r_state;
    w_pop = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_nxt = w_need ? SEL : w_head.swap_only ? IDLE : WRITE;
        w_pop = !w_need && w_head.swap_only;
      end
      SEL: w_nxt = STROBE;
      STROBE: begin
        w_nxt = w_head.swap_only ? IDLE : WRITE;
        w_pop = w_head.swap_only;
      end
      WRITE: begin
        w_nxt = IDLE;
        w_pop = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
  end
  // pulses are registered from the next state so they coincide exactly with STROBE/WRITE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_strobe <= 1'b0;
      r_sreg <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cur <= '0;
      r_known <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_write <= w_nxt == WRITE;
      r_strobe <= w_nxt == STROBE;
      if (w_nxt == SEL) r_sreg <= w_head.bank;
      if (w_nxt == WRITE) begin
        r_waddr <= w_head.addr;
        r_wdata <= w_head.data;
      end
      if (r_state == STROBE) begin
        r_cur <= w_head.bank;
        r_known <= 1'b1;
      end
    end
  assign bus.in_ready = !w_full;
  assign bus.write = r_write;
  assign bus.writeAddr = r_waddr;
  assign bus.writeData = r_wdata;
  assign bus.schwapReg = {2'b00, r_sreg};
  assign bus.schwapClk = r_strobe;
  assign bus.cur_bank = r_cur;
  assign bus.bank_known = r_known;
  assign bus.busy = !w_empty || r_state != IDLE;
endmodule

// File: tb/tb_schwap_writeback_seq.sv
// tb_schwap_writeback_seq: table vectors and hand sequences with a write/strobe scoreboard.
module tb_schwap_writeback_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  schwap_writeback_seq_if #(.DATA_W(16)) bus ();
  schwap_writeback_seq #(.DEPTH(2), .BANK_BASE(12), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {logic [3:0] a; logic [15:0] d;} wr_t;
  typedef struct {logic so; logic [3:0] a; logic [1:0] b; logic [15:0] d; logic es; logic [1:0] ecb;} vec_t;
  wr_t wq[$];
  logic [3:0] sq[$];
  vec_t tv[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.write || bus.schwapClk) chk("pulse_exclusive", 32'(bus.write & bus.schwapClk), 0);
    if (bus.write) begin
      chk("write_expected", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        wr_t e;
        e = wq.pop_front();
        chk("writeAddr", 32'(bus.writeAddr), 32'(e.a));
        chk("writeData", 32'(bus.writeData), 32'(e.d));
      end
    end
    if (bus.schwapClk) begin
      chk("strobe_expected", 32'(sq.size() > 0), 1);
      if (sq.size() > 0) chk("schwapReg_at_strobe", 32'(bus.schwapReg), 32'(sq.pop_front()));
    end
  end
  task automatic send(input logic so, input logic [3:0] a, input logic [1:0] b, input logic [15:0] d, input logic es);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_swap_only = so;
    bus.in_addr = a;
    bus.in_bank = b;
    bus.in_data = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        if (es) sq.push_back({2'b00, b});
        if (!so) wq.push_back('{a, d});
      end
      @(negedge clk);
    end
    chk("accepted", 32'(acc), 1);
  endtask
  task automatic wait_idle();
    bus.in_valid = 1'b0;
    for (int t = 0; t < 100 && bus.busy; t++) @(negedge clk);
    chk("idle_reached", 32'(bus.busy), 0);
    chk("scoreboard_drained", wq.size() + sq.size(), 0);
  endtask
  initial begin
    tv[0] = '{1'b0, 4'd14, 2'd2, 16'h0014, 1'b0, 2'd2};
    tv[1] = '{1'b0, 4'd14, 2'd1, 16'h0114, 1'b1, 2'd1};
    tv[2] = '{1'b0, 4'd5,  2'd3, 16'h0005, 1'b0, 2'd1};
    tv[3] = '{1'b0, 4'd12, 2'd1, 16'h1200, 1'b0, 2'd1};
    tv[4] = '{1'b0, 4'd11, 2'd2, 16'h0B0B, 1'b0, 2'd1};
    tv[5] = '{1'b1, 4'd0,  2'd3, 16'h0000, 1'b1, 2'd3};
    tv[6] = '{1'b1, 4'd0,  2'd3, 16'h0000, 1'b0, 2'd3};
    tv[7] = '{1'b1, 4'd0,  2'd0, 16'h0000, 1'b1, 2'd0};
    tv[8] = '{1'b0, 4'd15, 2'd3, 16'hFFFF, 1'b1, 2'd3};
    tv[9] = '{1'b0, 4'd15, 2'd3, 16'h5A5A, 1'b0, 2'd3};
    bus.in_valid = 1'b0;
    bus.in_swap_only = 1'b0;
    bus.in_addr = '0;
    bus.in_bank = '0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_write", 32'(bus.write), 0);
    chk("rst_schwapClk", 32'(bus.schwapClk), 0);
    chk("rst_outs", {bus.schwapReg, bus.writeAddr, bus.writeData, bus.cur_bank, bus.bank_known}, 0);
    send(1'b0, 4'd3, 2'd0, 16'h0003, 1'b0);
    bus.in_valid = 1'b0;
    chk("lat_write_early", 32'(bus.write), 0);
    @(negedge clk);
    chk("lat_write_2cyc", 32'(bus.write), 1);
    wait_idle();
    send(1'b0, 4'd13, 2'd2, 16'h000F, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sel_schwapReg", 32'(bus.schwapReg), 2);
    chk("sel_pulses", {bus.schwapClk, bus.write}, 0);
    @(negedge clk);
    chk("strobe_clk", 32'(bus.schwapClk), 1);
    chk("strobe_reg", 32'(bus.schwapReg), 2);
    @(negedge clk);
    chk("swap_write", 32'(bus.write), 1);
    chk("swap_write_reg_held", 32'(bus.schwapReg), 2);
    wait_idle();
    chk("swap_cur_bank", 32'(bus.cur_bank), 2);
    chk("swap_bank_known", 32'(bus.bank_known), 1);
    for (int i = 0; i < 10; i++) begin
      send(tv[i].so, tv[i].a, tv[i].b, tv[i].d, tv[i].es);
      wait_idle();
      chk($sformatf("vec%0d_cur_bank", i), 32'(bus.cur_bank), 32'(tv[i].ecb));
      chk($sformatf("vec%0d_bank_known", i), 32'(bus.bank_known), 1);
    end
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 4'(i), 2'd0, 16'(i), 1'b0);
      if (i == 1) chk("burst_full_ready", 32'(bus.in_ready), 0);
    end
    wait_idle();
    send(1'b0, 4'd13, 2'd0, 16'h1313, 1'b1);
    send(1'b0, 4'd2, 2'd0, 16'h0202, 1'b0);
    bus.in_valid = 1'b0;
    for (int t = 0; t < 20 && !bus.schwapClk; t++) @(negedge clk);
    chk("pre_rst_strobe", 32'(bus.schwapClk), 1);
    chk("pre_rst_queued", 32'(bus.in_ready), 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pulses", {bus.schwapClk, bus.write}, 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_bank", {bus.schwapReg, bus.cur_bank, bus.bank_known}, 0);
    wq.delete();
    sq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 0);
    send(1'b0, 4'd13, 2'd0, 16'h2222, 1'b1);
    wait_idle();
    chk("post_rst_cur_bank", 32'(bus.cur_bank), 0);
    chk("post_rst_known", 32'(bus.bank_known), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
